// File: rtl/mm2s_stream_checker_if.sv
// AXI-Stream bundle between the datamover MM2S port and the read-back checker.
// The master drives payload and valid; the slave drives ready.
interface mm2s_stream_checker_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/mm2s_stream_checker.sv
// Checks the MM2S read-back stream against an incrementing pattern while
// throttling tready to model a slow downstream link.
module mm2s_stream_checker #(
    parameter int DATA_W  = 64,
    parameter int RD_DIV  = 7,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     seed,
    input  logic [23:0]           beats,
    mm2s_stream_checker_if.slave  s_axis,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic                  tlast_err,
    output logic [15:0]           err_count,
    output logic [23:0]           beat_count,
    output logic [23:0]           first_err_index,
    output logic [DATA_W-1:0]     first_err_data
);
    localparam int KW = DATA_W / 8;
    localparam int DW = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DIV_RELOAD = DW'(RD_DIV - 1);
    localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [WW-1:0]       wdog_q, wdog_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [23:0]         tgt_q, tgt_d;
    logic                timeout_q, timeout_d;
    logic                tlast_err_q, tlast_err_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [23:0]         beat_count_q, beat_count_d;
    logic [23:0]         first_err_index_q, first_err_index_d;
    logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;

    logic tready;
    logic accept;
    logic last_beat;
    logic mismatch;

    // Ready comes purely from registers so there is no path from tvalid.
    assign tready    = (state_q == RUN) && (div_cnt_q == '0);
    assign accept    = s_axis.tvalid && tready;
    assign last_beat = (beat_count_q == (tgt_q - 24'd1));

    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < KW; i++) begin
            if (s_axis.tkeep[i] &&
                (s_axis.tdata[8*i +: 8] != exp_q[8*i +: 8])) begin
                mismatch = 1'b1;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        div_cnt_d         = div_cnt_q;
        wdog_d            = wdog_q;
        exp_d             = exp_q;
        tgt_d             = tgt_q;
        timeout_d         = timeout_q;
        tlast_err_d       = tlast_err_q;
        err_count_d       = err_count_q;
        beat_count_d      = beat_count_q;
        first_err_index_d = first_err_index_q;
        first_err_data_d  = first_err_data_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        exp_d             = seed;
                        tgt_d             = beats;
                        err_count_d       = '0;
                        beat_count_d      = '0;
                        first_err_index_d = '0;
                        first_err_data_d  = '0;
                        timeout_d         = 1'b0;
                        tlast_err_d       = 1'b0;
                        div_cnt_d         = DIV_RELOAD;
                        wdog_d            = '0;
                        state_d           = (beats == 24'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    div_cnt_d = (div_cnt_q == '0) ? DIV_RELOAD
                                                  : div_cnt_q - DW'(1);
                    if (accept) begin
                        wdog_d = '0;
                        if (mismatch) begin
                            if (err_count_q != 16'hFFFF) begin
                                err_count_d = err_count_q + 16'd1;
                            end
                            if (err_count_q == 16'd0) begin
                                first_err_index_d = beat_count_q;
                                first_err_data_d  = s_axis.tdata;
                            end
                        end
                        if (s_axis.tlast != last_beat) begin
                            tlast_err_d = 1'b1;
                        end
                        exp_d        = exp_q + DATA_W'(1);
                        beat_count_d = beat_count_q + 24'd1;
                        if (last_beat) begin
                            state_d = DONE;
                        end
                    end else if (wdog_q == WD_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        wdog_d = wdog_q + WW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            div_cnt_q         <= '0;
            wdog_q            <= '0;
            exp_q             <= '0;
            tgt_q             <= '0;
            timeout_q         <= 1'b0;
            tlast_err_q       <= 1'b0;
            err_count_q       <= '0;
            beat_count_q      <= '0;
            first_err_index_q <= '0;
            first_err_data_q  <= '0;
        end else begin
            state_q           <= state_d;
            div_cnt_q         <= div_cnt_d;
            wdog_q            <= wdog_d;
            exp_q             <= exp_d;
            tgt_q             <= tgt_d;
            timeout_q         <= timeout_d;
            tlast_err_q       <= tlast_err_d;
            err_count_q       <= err_count_d;
            beat_count_q      <= beat_count_d;
            first_err_index_q <= first_err_index_d;
            first_err_data_q  <= first_err_data_d;
        end
    end

    assign s_axis.tready   = tready;
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign pass            = (state_q == DONE) && (err_count_q == 16'd0) &&
                             !tlast_err_q && !timeout_q;
    assign timeout         = timeout_q;
    assign tlast_err       = tlast_err_q;
    assign err_count       = err_count_q;
    assign beat_count      = beat_count_q;
    assign first_err_index = first_err_index_q;
    assign first_err_data  = first_err_data_q;
endmodule

// File: tb/tb_mm2s_stream_checker.sv
// Scoreboard bench: expected transfer summaries are queued at start and
// compared by a monitor each time done rises.
module tb_mm2s_stream_checker;
    localparam int DW   = 64;
    localparam int RDIV = 7;
    localparam int TO   = 100;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] seed = '0;
    logic [23:0]   beats = '0;
    logic          busy, done, pass, timeout, tlast_err;
    logic [15:0]   err_count;
    logic [23:0]   beat_count, first_err_index;
    logic [DW-1:0] first_err_data;

    mm2s_stream_checker_if #(.DATA_W(DW)) tif ();

    mm2s_stream_checker #(
        .DATA_W (DW),
        .RD_DIV (RDIV),
        .TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .seed           (seed),
        .beats          (beats),
        .s_axis         (tif),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .tlast_err      (tlast_err),
        .err_count      (err_count),
        .beat_count     (beat_count),
        .first_err_index(first_err_index),
        .first_err_data (first_err_data)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          pass;
        int          errs;
        int          bcnt;
        bit          to;
        bit          tl;
        logic [23:0] fidx;
        logic [63:0] fdata;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] bd[$];
    logic [7:0]  bk[$];
    bit          bl[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: walk the beats the source actually delivered.
    function automatic exp_t model(input logic [63:0] sd, input int tgt,
                                   input int n);
        exp_t        e;
        int          got;
        logic [63:0] ev;
        bit          bad;
        e.pass = 1'b0; e.errs = 0; e.bcnt = 0; e.to = 1'b0; e.tl = 1'b0;
        e.fidx = '0; e.fdata = '0;
        got = (n < tgt) ? n : tgt;
        for (int k = 0; k < got; k++) begin
            ev  = sd + 64'(k);
            bad = 1'b0;
            for (int b = 0; b < 8; b++)
                if (bk[k][b] && (bd[k][8*b +: 8] != ev[8*b +: 8])) bad = 1'b1;
            if (bad) begin
                if (e.errs == 0) begin
                    e.fidx  = 24'(k);
                    e.fdata = bd[k];
                end
                if (e.errs < 65535) e.errs++;
            end
            if (bl[k] != (k == tgt - 1)) e.tl = 1'b1;
        end
        e.bcnt = got;
        e.to   = (got < tgt);
        e.pass = (e.errs == 0) && !e.tl && !e.to;
        return e;
    endfunction

    logic done_prev = 1'b0;
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (sbq.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got 1 expected 0");
                end else begin
                    me = sbq.pop_front();
                    chk("sb_pass", 64'(pass), 64'(me.pass));
                    chk("sb_err_count", 64'(err_count), 64'(me.errs));
                    chk("sb_beat_count", 64'(beat_count), 64'(me.bcnt));
                    chk("sb_timeout", 64'(timeout), 64'(me.to));
                    chk("sb_tlast_err", 64'(tlast_err), 64'(me.tl));
                    chk("sb_first_err_index", 64'(first_err_index),
                        64'(me.fidx));
                    chk("sb_first_err_data", first_err_data, me.fdata);
                end
            end
            done_prev = done;
        end
    end

    task automatic build(input logic [63:0] sd, input int tgt);
        bd.delete(); bk.delete(); bl.delete();
        for (int k = 0; k < tgt; k++) begin
            bd.push_back(sd + 64'(k));
            bk.push_back(8'hFF);
            bl.push_back(k == tgt - 1);
        end
    endtask

    task automatic drive(input int i);
        tif.tdata = bd[i];
        tif.tkeep = bk[i];
        tif.tlast = bl[i];
    endtask

    task automatic pulse_start(input logic [63:0] sd, input int tgt);
        @(negedge clk);
        seed  = sd;
        beats = 24'(tgt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int n, input bit gaps, input bit rate,
                        input int ab_at, input int mid);
        int i     = 0;
        int guard = 0;
        int last  = -1;
        bit mdone = 1'b0;
        if (n > 0) drive(0);
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            start      = 1'b0;
            tif.tvalid = !(gaps && ($urandom_range(0, 7) == 0));
            if (i == mid && !mdone) begin
                mdone = 1'b1;
                seed  = ~seed;
                beats = 24'd1;
                start = 1'b1;
            end
            if (i == ab_at && tif.tready) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                return;
            end
            if (tif.tvalid && tif.tready) begin
                if (rate && last >= 0)
                    chk("accept_interval", 64'(cyc - last), 64'(RDIV));
                last = cyc;
                @(posedge clk);
                #1;
                i++;
                if (i < n) drive(i);
            end
        end
        tif.tvalid = 1'b0;
        start      = 1'b0;
        if (i < n) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_budget: accepted %0d required %0d", i, n);
        end
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done"}, 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic run(input logic [63:0] sd, input int tgt, input int n,
                       input bit gaps, input bit rate, input int mid,
                       input string nm);
        sbq.push_back(model(sd, tgt, n));
        pulse_start(sd, tgt);
        send(n, gaps, rate, -1, mid);
        if (n == tgt) begin
            chk({nm, "_tready_after_last"}, 64'(tif.tready), 64'd0);
            chk({nm, "_done_after_last"}, 64'(done), 64'd1);
        end
        wait_done(nm);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_tready"}, 64'(tif.tready), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
        chk({nm, "_pass"}, 64'(pass), 64'd0);
        chk({nm, "_timeout"}, 64'(timeout), 64'd0);
        chk({nm, "_tlast_err"}, 64'(tlast_err), 64'd0);
        chk({nm, "_err_count"}, 64'(err_count), 64'd0);
        chk({nm, "_beat_count"}, 64'(beat_count), 64'd0);
        chk({nm, "_first_err_index"}, 64'(first_err_index), 64'd0);
        chk({nm, "_first_err_data"}, first_err_data, 64'd0);
    endtask

    initial begin
        int          tgt;
        int          seen;
        logic [63:0] sd;
        tif.tvalid = 1'b0;
        tif.tdata  = '0;
        tif.tkeep  = '0;
        tif.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset_n = 1'b1;
        @(negedge clk);

        build(64'h5, 0);
        run(64'h5, 0, 0, 1'b0, 1'b0, -1, "zero");

        build(64'h0, 16);
        run(64'h0, 16, 16, 1'b0, 1'b1, -1, "good");

        build(64'h0, 16);
        bd[5] = 64'h1234;
        run(64'h0, 16, 16, 1'b1, 1'b0, 2, "bad5");

        build(64'hFFFF_FFFF_FFFF_FFFE, 4);
        run(64'hFFFF_FFFF_FFFF_FFFE, 4, 4, 1'b0, 1'b0, -1, "wrap");

        build(64'h0, 8);
        bl[3] = 1'b1;
        run(64'h0, 8, 8, 1'b0, 1'b0, -1, "early_last");

        build(64'h100, 8);
        bk[2] = 8'h0F;
        bd[2] = bd[2] ^ 64'hA5A5_5A5A_0000_0000;
        run(64'h100, 8, 8, 1'b0, 1'b0, -1, "keep");

        build(64'h77, 10);
        run(64'h77, 10, 5, 1'b0, 1'b0, -1, "tmo");
        chk("tmo_timeout_flag", 64'(timeout), 64'd1);

        build(64'h900, 10);
        run(64'h900, 10, 10, 1'b0, 1'b0, -1, "recover");

        for (int r = 0; r < 6; r++) begin
            tgt = $urandom_range(1, 12);
            sd  = {$urandom, $urandom};
            build(sd, tgt);
            for (int k = 0; k < tgt; k++) begin
                case ($urandom_range(0, 11))
                    0, 1: bd[k] = bd[k] ^ (64'($urandom_range(1, 255))
                                  << (8 * $urandom_range(0, 7)));
                    2: bk[k] = 8'($urandom);
                    3: bl[k] = !bl[k];
                    default: ;
                endcase
            end
            run(sd, tgt, tgt, 1'b1, 1'b0, -1, "rnd");
        end

        build(64'h0, 10);
        pulse_start(64'h0, 10);
        send(10, 1'b0, 1'b0, 3, -1);
        tif.tvalid = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (tif.tready) seen++;
        end
        tif.tvalid = 1'b0;
        chk("abort_tready_seen", 64'(seen), 64'd0);
        chk("abort_beat_count", 64'(beat_count), 64'd3);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);

        build(64'h0, 10);
        bd[0] = 64'hDEAD;
        pulse_start(64'h0, 10);
        send(2, 1'b0, 1'b0, -1, -1);
        chk("pre_reset_beat_count", 64'(beat_count), 64'd2);
        chk("pre_reset_err_count", 64'(err_count), 64'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
